outpkt_arbiter: RTL
===================

Name: outpkt_arbiter

Overview:
- Shares the single 16-bit output FIFO write port (dout/wr_en/full) between N output-packet sources, each a checksummed, framed 16-bit word stream.
- Grants whole packets round-robin and never interleaves words of different packets.
- Sits between the per-subsystem outpkt_checksum instances and the high-speed output FIFO in pkt_comm.
- Exposes grant, busy, packet count and error status for the VCR status bytes.

Parameters:
- N_SRC, 2: number of requesting sources; range 2..8.
- MAX_PKT_WORDS, 8*65536: word count at which a packet with no pkt_end is flagged as overlong.
- CNT_MSB, `MSB(MAX_PKT_WORDS): MSB of the in-packet word counter.

Ports:
- CLK  in  1  clock; all logic runs in this single domain.
- RST_N  in  1  asynchronous active-low reset.
- enable  in  1  arbitration enable; pkt_comm drives it from app_mode==2.
- src_dout  in  N_SRC*16  source words; source i occupies bits [16*i+15:16*i]; first-word-fall-through.
- src_pkt_end  in  N_SRC  marks the current head word as the last word of its packet.
- src_empty  in  N_SRC  source has no valid head word.
- src_rd_en  out  N_SRC  pops the head word of the granted source.
- dout  out  16  word to the output FIFO.
- wr_en  out  1  output FIFO write strobe.
- full  in  1  output FIFO full.
- busy  out  1  a packet transfer is in progress.
- grant_id  out  `MSB(N_SRC-1)+1  index of the currently or last granted source.
- pkt_count  out  16  number of packets completed; wraps modulo 2^16.
- err_pkt_overlong  out  1  sticky overlong-packet flag.

Behaviour:
- Reset (RST_N low, asynchronous):
  - state=IDLE, last_grant=N_SRC-1, grant_id=0, word_cnt=0, pkt_count=0, err_pkt_overlong=0.
  - Outputs: src_rd_en=0, wr_en=0, dout=0, busy=0.
  - Asserting reset mid-packet abandons that packet; the remainder stays in the source, no recovery is attempted.
- IDLE state:
  - If enable=1 and any src_empty[i]=0, pick the first non-empty source scanning last_grant+1, last_grant+2, ... modulo N_SRC.
  - Register the pick into grant_id; clear word_cnt; go to XFER.
  - This costs one bubble cycle per packet. No words move in IDLE.
- XFER state, with g = grant_id:
  - src_rd_en[g] = ~src_empty[g] & ~full, combinational; all other src_rd_en bits are 0.
  - wr_en = src_rd_en[g].
  - dout = src_dout[g] while in XFER, else 0.
  - Zero added latency: the source word appears at dout in the same cycle.
- Word accounting on each transfer (src_rd_en[g]=1):
  - word_cnt increments and saturates at MAX_PKT_WORDS.
  - If word_cnt reaches MAX_PKT_WORDS with no pkt_end, set err_pkt_overlong. The transfer continues and the grant is held; the flag clears only on reset.
- End of packet (src_rd_en[g]=1 and src_pkt_end[g]=1):
  - Next cycle: state=IDLE, last_grant=g, pkt_count+1 (wraps 0xFFFF -> 0).
- Stalls:
  - full=1 or src_empty[g]=1 mid-packet stalls the transfer with no timeout, grant held.
  - The other sources are not served until the packet ends.
- enable deasserted:
  - In XFER the current packet completes normally.
  - In IDLE no new grant is issued.
- busy = (state==XFER).
- Simultaneous requests: exactly one grant per arbitration. A source that just finished has the lowest priority next round.
- A single-word packet (pkt_end on its first word) takes 2 cycles per packet including the bubble.

Decomposition:
- Shared package, beside the PKT_TYPE_* constants:
  - OUTPKT_WORD_BITS=16;
  - state encoding (IDLE=1'b0, XFER=1'b1);
  - N_SRC default;
  - source index assignment: SRC_WORD=0, SRC_STATUS=1.
- Sub-module outpkt_rr_select:
  - combinational round-robin picker;
  - inputs: req vector, last_grant;
  - outputs: idx, valid;
  - instantiated once.

Test Plan:
- Reset mid-packet: assert RST_N low during XFER -> outputs immediately 0, state IDLE, pkt_count=0, err_pkt_overlong=0.
- Single source: source 0 holds a 5-word packet (0x0001..0x0005, end on 0x0005), full=0 -> wr_en high 5 consecutive cycles after a 1-cycle bubble; dout 0x0001..0x0005; pkt_count=1.
- Two sources, both non-empty: each has two 3-word packets -> grant order 0,1,0,1; words never interleaved; pkt_count=4.
- Backpressure: full toggles every other cycle during a 4-word packet -> each word written exactly once, in order; src_rd_en is never high while full=1.
- Source starves: src_empty[g]=1 for 10 cycles mid-packet while source 1 is ready -> grant held, no writes from source 1 until source 0 sends pkt_end.
- Overlong packet, MAX_PKT_WORDS=8: 10-word packet -> err_pkt_overlong set on the 8th word and stays set; all 10 words pass; pkt_count increments once.

Source files
------------

// File: rtl/outpkt_arbiter_pkg.sv
// Shared definitions for the output-packet arbiter: word width, source
// indices and the arbiter state encoding.
package outpkt_arbiter_pkg;

  localparam int unsigned OUTPKT_WORD_BITS = 16;
  localparam int unsigned OUTPKT_N_SRC     = 2;

  localparam int unsigned SRC_WORD   = 0;
  localparam int unsigned SRC_STATUS = 1;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_XFER = 1'b1
  } outpkt_state_e;

  // Index reached by stepping `step` places past `base` in a ring of n.
  function automatic int unsigned rr_wrap(input int unsigned base,
                                          input int unsigned step,
                                          input int unsigned n);
    return (base + step) % n;
  endfunction

endpackage

// File: rtl/outpkt_rr_select.sv
// Combinational round-robin picker: first requester after last_grant,
// wrapping modulo N.
module outpkt_rr_select
  import outpkt_arbiter_pkg::*;
#(
  parameter int unsigned N  = OUTPKT_N_SRC,
  parameter int unsigned IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] last_grant,
  output logic [IW-1:0] idx,
  output logic          valid
);

  logic [2*N-1:0] req2;
  logic [N-1:0]   rot;

  // Rotate a doubled request vector so bit 0 is the source just after last_grant.
  always_comb begin
    req2  = {req, req};
    rot   = N'(req2 >> (32'(last_grant) + 32'd1));
    idx   = '0;
    valid = 1'b0;
    for (int unsigned k = 0; k < N; k++) begin
      if (!valid && rot[k]) begin
        valid = 1'b1;
        idx   = IW'(rr_wrap(32'(last_grant), k + 1, N));
      end
    end
  end

endmodule

// File: rtl/outpkt_arbiter.sv
// Round-robin, packet-granular sharing of the 16-bit output FIFO write port
// between N_SRC first-word-fall-through packet sources.
module outpkt_arbiter
  import outpkt_arbiter_pkg::*;
#(
  parameter int unsigned N_SRC         = OUTPKT_N_SRC,
  parameter int unsigned MAX_PKT_WORDS = 8 * 65536,
  parameter int unsigned CNT_MSB       = $clog2(MAX_PKT_WORDS + 1) - 1,
  localparam int unsigned GW           = $clog2(N_SRC),
  localparam int unsigned W            = OUTPKT_WORD_BITS
) (
  input  logic               CLK,
  input  logic               RST_N,
  input  logic               enable,
  input  logic [N_SRC*W-1:0] src_dout,
  input  logic [N_SRC-1:0]   src_pkt_end,
  input  logic [N_SRC-1:0]   src_empty,
  output logic [N_SRC-1:0]   src_rd_en,
  output logic [W-1:0]       dout,
  output logic               wr_en,
  input  logic               full,
  output logic               busy,
  output logic [GW-1:0]      grant_id,
  output logic [15:0]        pkt_count,
  output logic               err_pkt_overlong
);

  localparam int unsigned CW = CNT_MSB + 1;
  localparam logic [CNT_MSB:0] CNT_MAX = CW'(MAX_PKT_WORDS);

  outpkt_state_e    state_q;
  logic [GW-1:0]    grant_q;
  logic [GW-1:0]    last_grant_q;
  logic [CNT_MSB:0] word_cnt_q;
  logic [15:0]      pkt_count_q;
  logic             err_q;

  logic [N_SRC-1:0] src_req;
  logic [GW-1:0]    pick_idx;
  logic             pick_valid;

  logic [W-1:0]     head_word;
  logic             head_end;
  logic             head_empty;
  logic             xfer_go;
  logic [CNT_MSB:0] word_cnt_d;

  assign src_req = ~src_empty;

  outpkt_rr_select #(
    .N  (N_SRC),
    .IW (GW)
  ) u_rr_select (
    .req        (src_req),
    .last_grant (last_grant_q),
    .idx        (pick_idx),
    .valid      (pick_valid)
  );

  always_comb begin
    head_word  = '0;
    head_end   = 1'b0;
    head_empty = 1'b1;
    for (int unsigned i = 0; i < N_SRC; i++) begin
      if (grant_q == GW'(i)) begin
        head_word  = src_dout[i*W +: W];
        head_end   = src_pkt_end[i];
        head_empty = src_empty[i];
      end
    end
  end

  // Read and write are combinational so the head word reaches dout in the same cycle.
  always_comb begin
    xfer_go   = (state_q == ST_XFER) && !head_empty && !full;
    src_rd_en = '0;
    for (int unsigned i = 0; i < N_SRC; i++) begin
      if (grant_q == GW'(i)) src_rd_en[i] = xfer_go;
    end
    wr_en      = xfer_go;
    dout       = (state_q == ST_XFER) ? head_word : '0;
    word_cnt_d = (word_cnt_q == CNT_MAX) ? CNT_MAX : word_cnt_q + 1'b1;
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q      <= ST_IDLE;
      grant_q      <= '0;
      last_grant_q <= GW'(N_SRC - 1);
      word_cnt_q   <= '0;
      pkt_count_q  <= '0;
      err_q        <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (enable && pick_valid) begin
            grant_q    <= pick_idx;
            word_cnt_q <= '0;
            state_q    <= ST_XFER;
          end
        end
        ST_XFER: begin
          if (xfer_go) begin
            word_cnt_q <= word_cnt_d;
            if (word_cnt_d == CNT_MAX && !head_end) err_q <= 1'b1;
            if (head_end) begin
              state_q      <= ST_IDLE;
              last_grant_q <= grant_q;
              pkt_count_q  <= pkt_count_q + 16'd1;
            end
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign busy             = (state_q == ST_XFER);
  assign grant_id         = grant_q;
  assign pkt_count        = pkt_count_q;
  assign err_pkt_overlong = err_q;

endmodule
